dest_scoreboard: RTL and testbench
==================================

Name: dest_scoreboard

Overview:
- Sits directly downstream of the destination-select mux in the issue stage.
- Consumes the selected destination register address (rd or rt, per reg_dst) of up to two instructions per cycle.
- Tracks in-flight register writes with a per-register pending counter, and produces RAW/WAW stall signals for the dual-issue pair.
- Write-back ports retire pending writes.

Parameters:
AWIDTH, `AWIDTH (5), register address width
NREG, 32, number of architectural registers (2**AWIDTH)
CWIDTH, 2, pending-write counter width per register (max 3 in flight)

Ports:
sb_clk  in  1  clock, rising edge
sb_rst_n  in  1  asynchronous active-low reset
sb_i_valid0  in  1  slot-0 instruction present
sb_i_wen0  in  1  slot-0 writes a register
sb_i_rs0, sb_i_rt0  in  AWIDTH  slot-0 source addresses
sb_i_dst0  in  AWIDTH  slot-0 destination (mux output)
sb_i_valid1, sb_i_wen1, sb_i_rs1, sb_i_rt1, sb_i_dst1  in  1/1/AWIDTH/AWIDTH/AWIDTH  slot-1 equivalents
sb_i_wb_en0, sb_i_wb_en1  in  1  write-back retire strobes
sb_i_wb_addr0, sb_i_wb_addr1  in  AWIDTH  retired destination addresses
sb_i_flush  in  1  pipeline squash
sb_o_stall0  out  1  slot 0 must not issue this cycle
sb_o_stall1  out  1  slot 1 must not issue this cycle
sb_o_err  out  1  sticky underflow/overflow error

Behaviour:
- State: cnt[r], CWIDTH bits, r = 0..NREG-1. Register 0 is never tracked; cnt[0] reads as 0 always.
- Reset (async, sb_rst_n=0): all cnt = 0, sb_o_err = 0. Stalls are combinational, so with zero counters they reflect only intra-pair checks.
- busy(r) = (r != 0) && cnt[r] != 0.
- stall0 = valid0 && (busy(rs0) || busy(rt0) || (wen0 && dst0 != 0 && cnt[dst0] == 3)).
- stall1 = valid1 && (stall0 || busy(rs1) || busy(rt1) || (valid0 && wen0 && dst0 != 0 && (dst0 == rs1 || dst0 == rt1)) || cnt-capacity fail).
  - Capacity fail: the projected count for dst1, including slot 0's increment when dst0 == dst1, would exceed 3.
  - In-order rule: slot 1 never issues without slot 0 issuing.
- Issue fires iss_k = valid_k && !stall_k. On fire with wen_k && dst_k != 0, cnt[dst_k] increments at the next edge.
- Write-back: wb_en_j with wb_addr_j != 0 decrements cnt[wb_addr_j].
- Net update per register per cycle = (#issues to r) - (#write-backs to r), applied in one edge. Range is -2..+2.
  - Simultaneous issue and write-back to the same register nets out.
  - Both write-backs to the same address decrement by 2.
- Underflow: if the decrement would go below 0, cnt saturates at 0 and sb_o_err sets.
- Overflow: cannot occur given the stall rules. If it is detected anyway, saturate at 3 and set err.
- sb_o_err is sticky until reset.
- Flush: synchronous, highest priority. All cnt cleared at the next edge; issues and write-backs in that cycle are ignored. sb_o_err is unaffected.
- Latency: a destination issued in cycle N makes a dependent source stall from cycle N+1. Within cycle N, the intra-pair check covers it.
- Write-back in cycle N clears busy at cycle N+1; there is no same-cycle bypass.
- Reset asserted mid-operation clears all state immediately, regardless of clock.

Decomposition:
- Shared package/include holds `AWIDTH (existing), NREG, CWIDTH, and the counter max constant.
- One natural sub-module: sb_cnt_cell, a single register's counter.
  - Inputs: inc count (0..2), dec count (0..2), flush.
  - Outputs: busy, full, err pulse.
  - Instantiated NREG-1 times via generate.

Test Plan:
- Reset: assert sb_rst_n=0 mid-run with counters non-zero -> all cnt=0 immediately. Slot 0 with rs0=5 and no issue pending -> stall0=0.
- RAW across cycles: issue slot0 wen0=1, dst0=10 at N; at N+1 slot0 rs0=10 -> stall0=1. Write-back addr 10 at N+1 -> stall0=0 at N+2.
- Intra-pair: valid0, dst0=5, wen0; valid1, rt1=5 -> stall0=0, stall1=1; cnt[5]=1 next cycle.
- Register 0: dst0=0, wen0=1 issue, then rs0=0 -> never stalls, cnt[0] stays 0.
- WAW capacity: three issues to dst=7 without write-back -> cnt[7]=3. A fourth, with sources clear -> stall0=1. One write-back to 7 -> stall clears next cycle.
- Error/flush: write-back to addr 9 with cnt[9]=0 -> sb_o_err=1 and stays 1. Flush with cnt[3]=2 plus same-cycle write-back to 3 -> cnt[3]=0, err unchanged.

Source files
------------

// File: rtl/dest_scoreboard_pkg.sv
// dest_scoreboard_pkg
// Shared types and constants for the destination scoreboard.
// AWIDTH comes from the existing `AWIDTH macro (default 5); NREG, CWIDTH and
// the counter ceiling are derived here so every file agrees on them.

`ifndef AWIDTH
`define AWIDTH 5
`endif

package dest_scoreboard_pkg;

    localparam int AWIDTH = `AWIDTH;
    localparam int NREG   = 2 ** AWIDTH;
    localparam int CWIDTH = 2;

    typedef logic [AWIDTH-1:0] addr_t;
    typedef logic [CWIDTH-1:0] cnt_t;

    // Largest number of writes that may be in flight to one register.
    localparam cnt_t CNT_MAX = '1;

    // One issue slot as seen after the destination-select mux.
    typedef struct packed {
        logic  valid;
        logic  wen;
        addr_t rs;
        addr_t rt;
        addr_t dst;
    } slot_t;

    // How many of two qualified strobes target register r (0..2).
    function automatic logic [1:0] hitCount(input logic e0, input addr_t a0,
                                            input logic e1, input addr_t a1,
                                            input addr_t r);
        return {1'b0, (e0 && (a0 == r))} + {1'b0, (e1 && (a1 == r))};
    endfunction

endpackage

// File: rtl/dest_scoreboard_cell.sv
// sb_cnt_cell
// Pending-write counter for one architectural register.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc          : issues targeting this register this cycle (0..2)
//   i_dec          : write-backs retiring this register this cycle (0..2)
//   i_flush        : clear the counter, ignoring this cycle's inc/dec
//   o_cnt          : current count
//   o_busy, o_full : count non-zero / count at ceiling
//   o_err          : pulse when the net update leaves the legal range

module sb_cnt_cell
    import dest_scoreboard_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_inc,
    input  logic [1:0] i_dec,
    input  logic       i_flush,
    output cnt_t       o_cnt,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_err
);

    localparam int WW = CWIDTH + 2;

    cnt_t          r_cnt;
    logic [WW-1:0] w_up;
    logic [WW-1:0] w_net;
    logic          w_under;
    logic          w_over;
    cnt_t          w_next;

    // Increments are added before the decrement so that an issue and a
    // write-back landing in the same cycle net out instead of underflowing.
    always_comb begin
        w_up    = {2'b00, r_cnt} + WW'(i_inc);
        w_under = w_up < WW'(i_dec);
        w_net   = w_up - WW'(i_dec);
        w_over  = !w_under && (w_net > WW'(CNT_MAX));
        w_next  = w_net[CWIDTH-1:0];
        if (i_flush) begin
            w_next = '0;
        end else if (w_under) begin
            w_next = '0;
        end else if (w_over) begin
            w_next = CNT_MAX;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = (r_cnt != '0);
    assign o_full = (r_cnt == CNT_MAX);
    assign o_err  = !i_flush && (w_under || w_over);

endmodule

// File: rtl/dest_scoreboard.sv
// dest_scoreboard
// Tracks in-flight register writes for a dual-issue pair and produces the
// RAW/WAW stalls for both slots.
// Ports:
//   sb_clk, sb_rst_n                      : clock, async active-low reset
//   sb_i_valid/wen/rs/rt/dst{0,1}         : issue slots (dst is mux output)
//   sb_i_wb_en{0,1}, sb_i_wb_addr{0,1}    : write-back retire ports
//   sb_i_flush                            : synchronous squash of all counters
//   sb_o_stall0, sb_o_stall1              : combinational issue stalls
//   sb_o_err                              : sticky counter range error

module dest_scoreboard
    import dest_scoreboard_pkg::*;
(
    input  logic              sb_clk,
    input  logic              sb_rst_n,
    input  logic              sb_i_valid0,
    input  logic              sb_i_wen0,
    input  logic [AWIDTH-1:0] sb_i_rs0,
    input  logic [AWIDTH-1:0] sb_i_rt0,
    input  logic [AWIDTH-1:0] sb_i_dst0,
    input  logic              sb_i_valid1,
    input  logic              sb_i_wen1,
    input  logic [AWIDTH-1:0] sb_i_rs1,
    input  logic [AWIDTH-1:0] sb_i_rt1,
    input  logic [AWIDTH-1:0] sb_i_dst1,
    input  logic              sb_i_wb_en0,
    input  logic              sb_i_wb_en1,
    input  logic [AWIDTH-1:0] sb_i_wb_addr0,
    input  logic [AWIDTH-1:0] sb_i_wb_addr1,
    input  logic              sb_i_flush,
    output logic              sb_o_stall0,
    output logic              sb_o_stall1,
    output logic              sb_o_err
);

    slot_t            w_s0;
    slot_t            w_s1;
    cnt_t             w_cnt [NREG];
    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_full;
    logic [NREG-1:0]  w_err;
    logic             w_wr0;
    logic             w_wr1;
    logic             w_same01;
    logic [2:0]       w_proj1;
    logic             w_cap1;
    logic             w_pair_raw;
    logic             w_stall0;
    logic             w_stall1;
    logic             w_iss0;
    logic             w_iss1;
    logic             r_err;

    assign w_s0 = '{valid: sb_i_valid0, wen: sb_i_wen0, rs: sb_i_rs0,
                    rt: sb_i_rt0, dst: sb_i_dst0};
    assign w_s1 = '{valid: sb_i_valid1, wen: sb_i_wen1, rs: sb_i_rs1,
                    rt: sb_i_rt1, dst: sb_i_dst1};

    // Register 0 is hard-wired untracked: it never looks busy or full.
    assign w_cnt[0]  = '0;
    assign w_busy[0] = 1'b0;
    assign w_full[0] = 1'b0;
    assign w_err[0]  = 1'b0;

    assign w_wr0 = w_s0.wen && (w_s0.dst != '0);
    assign w_wr1 = w_s1.wen && (w_s1.dst != '0);

    // Slot 1 capacity counts slot 0's pending increment when both target the
    // same register; write-backs are not credited this cycle.
    assign w_same01   = w_s0.valid && w_wr0 && (w_s0.dst == w_s1.dst);
    assign w_proj1    = {1'b0, w_cnt[w_s1.dst]} + {2'b00, w_same01} + 3'd1;
    assign w_cap1     = w_wr1 && (w_proj1 > {1'b0, CNT_MAX});
    assign w_pair_raw = w_s0.valid && w_wr0 &&
                        ((w_s0.dst == w_s1.rs) || (w_s0.dst == w_s1.rt));

    // Slot 1 stalls whenever slot 0 does not issue, keeping issue in order.
    assign w_stall0 = w_s0.valid &&
                      (w_busy[w_s0.rs] || w_busy[w_s0.rt] ||
                       (w_wr0 && w_full[w_s0.dst]));
    assign w_stall1 = w_s1.valid &&
                      (!w_s0.valid || w_stall0 ||
                       w_busy[w_s1.rs] || w_busy[w_s1.rt] ||
                       w_pair_raw || w_cap1);

    assign w_iss0 = w_s0.valid && !w_stall0;
    assign w_iss1 = w_s1.valid && !w_stall1;

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        logic [1:0] w_inc;
        logic [1:0] w_dec;

        assign w_inc = hitCount(w_iss0 && w_s0.wen, w_s0.dst,
                                w_iss1 && w_s1.wen, w_s1.dst, addr_t'(r));
        assign w_dec = hitCount(sb_i_wb_en0, sb_i_wb_addr0,
                                sb_i_wb_en1, sb_i_wb_addr1, addr_t'(r));

        sb_cnt_cell u_cell (
            .i_clk   (sb_clk),
            .i_rst_n (sb_rst_n),
            .i_inc   (w_inc),
            .i_dec   (w_dec),
            .i_flush (sb_i_flush),
            .o_cnt   (w_cnt[r]),
            .o_busy  (w_busy[r]),
            .o_full  (w_full[r]),
            .o_err   (w_err[r])
        );
    end

    // Error flag latches any cell's range violation until reset; flush
    // leaves it alone.
    always_ff @(posedge sb_clk or negedge sb_rst_n) begin
        if (!sb_rst_n) begin
            r_err <= 1'b0;
        end else if (|w_err) begin
            r_err <= 1'b1;
        end
    end

    assign sb_o_stall0 = w_stall0;
    assign sb_o_stall1 = w_stall1;
    assign sb_o_err    = r_err;

endmodule

// File: tb/tb_dest_scoreboard.sv
// tb_dest_scoreboard
// Self-checking bench for dest_scoreboard: directed scenarios followed by a
// randomized run, all compared against a per-register count model.

module tb_dest_scoreboard;
    import dest_scoreboard_pkg::*;

    logic  clk;
    logic  rstN;
    logic  v0, w0, v1, w1;
    addr_t rs0, rt0, d0, rs1, rt1, d1;
    logic  wbe0, wbe1;
    addr_t wba0, wba1;
    logic  flush;
    logic  stall0, stall1, err;

    int checks;
    int errors;

    // Behavioural model: plain integer counts per register plus sticky error.
    int mCnt [NREG];
    bit mErr;

    dest_scoreboard dut (
        .sb_clk        (clk),
        .sb_rst_n      (rstN),
        .sb_i_valid0   (v0),
        .sb_i_wen0     (w0),
        .sb_i_rs0      (rs0),
        .sb_i_rt0      (rt0),
        .sb_i_dst0     (d0),
        .sb_i_valid1   (v1),
        .sb_i_wen1     (w1),
        .sb_i_rs1      (rs1),
        .sb_i_rt1      (rt1),
        .sb_i_dst1     (d1),
        .sb_i_wb_en0   (wbe0),
        .sb_i_wb_en1   (wbe1),
        .sb_i_wb_addr0 (wba0),
        .sb_i_wb_addr1 (wba1),
        .sb_i_flush    (flush),
        .sb_o_stall0   (stall0),
        .sb_o_stall1   (stall1),
        .sb_o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit mBusy(input int r);
        return (r != 0) && (mCnt[r] != 0);
    endfunction

    function automatic bit mStall0();
        return v0 && (mBusy(int'(rs0)) || mBusy(int'(rt0)) ||
                      (w0 && d0 != 0 && mCnt[int'(d0)] == 3));
    endfunction

    function automatic bit mStall1();
        int proj;
        proj = mCnt[int'(d1)] + ((v0 && w0 && d0 == d1) ? 1 : 0) + 1;
        return v1 && (!v0 || mStall0() || mBusy(int'(rs1)) || mBusy(int'(rt1)) ||
                      (v0 && w0 && d0 != 0 && (d0 == rs1 || d0 == rt1)) ||
                      (w1 && d1 != 0 && proj > 3));
    endfunction

    function automatic void modelReset();
        for (int r = 0; r < NREG; r++) mCnt[r] = 0;
        mErr = 1'b0;
    endfunction

    task automatic idle();
        v0 = 0; w0 = 0; rs0 = 0; rt0 = 0; d0 = 0;
        v1 = 0; w1 = 0; rs1 = 0; rt1 = 0; d1 = 0;
        wbe0 = 0; wbe1 = 0; wba0 = 0; wba1 = 0; flush = 0;
    endtask

    // Advance one clock edge, applying the model's view of this cycle.
    task automatic tick();
        bit iss0, iss1;
        int n;
        iss0 = v0 && !mStall0();
        iss1 = v1 && !mStall1();
        @(posedge clk);
        if (flush) begin
            for (int r = 0; r < NREG; r++) mCnt[r] = 0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                n = mCnt[r];
                if (iss0 && w0 && int'(d0) == r) n++;
                if (iss1 && w1 && int'(d1) == r) n++;
                if (wbe0 && int'(wba0) == r) n--;
                if (wbe1 && int'(wba1) == r) n--;
                if (n < 0) begin n = 0; mErr = 1'b1; end
                if (n > 3) begin n = 3; mErr = 1'b1; end
                mCnt[r] = n;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rstN = 0;
        modelReset();
        #2;
        v0 = 1; rs0 = 5;
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err actual=%b expected=0", err); end
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall0 actual=%b expected=0", stall0); end
        #3 rstN = 1;
        idle();
        tick();
    endtask

    task automatic test_raw();
        idle(); v0 = 1; w0 = 1; d0 = 10;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL raw_issue actual=%b expected=0", stall0); end
        tick();
        idle(); v0 = 1; rs0 = 10; wbe0 = 1; wba0 = 10;
        #3;
        checks++;
        if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall actual=%b expected=1", stall0); end
        tick();
        idle(); v0 = 1; rs0 = 10;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL raw_after_wb actual=%b expected=0", stall0); end
        tick();
    endtask

    task automatic test_intra_pair();
        idle(); v0 = 1; w0 = 1; d0 = 5; v1 = 1; rt1 = 5;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL pair_stall0 actual=%b expected=0", stall0); end
        checks++;
        if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL pair_stall1 actual=%b expected=1", stall1); end
        tick();
        idle(); v0 = 1; rs0 = 5; wbe0 = 1; wba0 = 5;
        #3;
        checks++;
        if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL pair_cnt5_busy actual=%b expected=1", stall0); end
        tick();
        // Slot 1 alone must wait for slot 0.
        idle(); v1 = 1;
        #3;
        checks++;
        if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL in_order actual=%b expected=1", stall1); end
        tick();
    endtask

    task automatic test_reg0();
        idle(); v0 = 1; w0 = 1; d0 = 0;
        tick();
        idle(); v0 = 1; w0 = 1; d0 = 0; v1 = 1; rs1 = 0; rt1 = 0;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL reg0_stall0 actual=%b expected=0", stall0); end
        checks++;
        if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL reg0_stall1 actual=%b expected=0", stall1); end
        tick();
    endtask

    task automatic test_waw_capacity();
        for (int i = 0; i < 2; i++) begin
            idle(); v0 = 1; w0 = 1; d0 = 7;
            tick();
        end
        idle(); v0 = 1; w0 = 1; d0 = 7; v1 = 1; w1 = 1; d1 = 7;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL waw_third actual=%b expected=0", stall0); end
        checks++;
        if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL waw_cap1 actual=%b expected=1", stall1); end
        tick();
        idle(); v0 = 1; w0 = 1; d0 = 7; wbe0 = 1; wba0 = 7;
        #3;
        checks++;
        if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL waw_full actual=%b expected=1", stall0); end
        tick();
        idle(); v0 = 1; w0 = 1; d0 = 7;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL waw_freed actual=%b expected=0", stall0); end
        tick();
        idle(); wbe0 = 1; wba0 = 7; wbe1 = 1; wba1 = 7;
        tick();
        idle(); wbe0 = 1; wba0 = 7;
        tick();
        idle(); v0 = 1; rs0 = 7;
        #3;
        checks++;
        if (stall0 !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL waw_drain stall0=%b err=%b expected 0/0", stall0, err);
        end
        tick();
    endtask

    task automatic test_err_flush();
        idle(); wbe1 = 1; wba1 = 9;
        tick();
        idle();
        #3;
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL underflow_err actual=%b expected=1", err); end
        for (int i = 0; i < 2; i++) begin
            idle(); v0 = 1; w0 = 1; d0 = 3;
            tick();
        end
        idle(); v0 = 1; rs0 = 3; flush = 1; wbe0 = 1; wba0 = 3;
        #3;
        checks++;
        if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre actual=%b expected=1", stall0); end
        tick();
        idle(); v0 = 1; rs0 = 3;
        #3;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL flush_clear actual=%b expected=0", stall0); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky actual=%b expected=1", err); end
        tick();
    endtask

    task automatic test_async_reset();
        idle(); v0 = 1; w0 = 1; d0 = 12;
        tick();
        idle(); v0 = 1; rs0 = 12;
        #3;
        checks++;
        if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre actual=%b expected=1", stall0); end
        rstN = 0;
        modelReset();
        #1;
        checks++;
        if (stall0 !== 1'b0) begin errors++; $display("[TB] FAIL areset_stall actual=%b expected=0", stall0); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL areset_err actual=%b expected=0", err); end
        #1 rstN = 1;
        idle();
        tick();
    endtask

    task automatic test_random();
        bit e0, e1;
        for (int i = 0; i < 400; i++) begin
            v0    = ($urandom_range(0, 3) != 0);
            w0    = $urandom_range(0, 1);
            rs0   = addr_t'($urandom_range(0, 7));
            rt0   = addr_t'($urandom_range(0, 7));
            d0    = addr_t'($urandom_range(0, 7));
            v1    = ($urandom_range(0, 3) != 0);
            w1    = $urandom_range(0, 1);
            rs1   = addr_t'($urandom_range(0, 7));
            rt1   = addr_t'($urandom_range(0, 7));
            d1    = addr_t'($urandom_range(0, 7));
            wbe0  = ($urandom_range(0, 2) == 0);
            wbe1  = ($urandom_range(0, 3) == 0);
            wba0  = addr_t'($urandom_range(0, 7));
            wba1  = addr_t'($urandom_range(0, 7));
            flush = ($urandom_range(0, 31) == 0);
            #3;
            e0 = mStall0();
            e1 = mStall1();
            checks++;
            if (stall0 !== e0) begin errors++; $display("[TB] FAIL rand_stall0 cyc=%0d actual=%b expected=%b", i, stall0, e0); end
            checks++;
            if (stall1 !== e1) begin errors++; $display("[TB] FAIL rand_stall1 cyc=%0d actual=%b expected=%b", i, stall1, e1); end
            checks++;
            if (err !== mErr) begin errors++; $display("[TB] FAIL rand_err cyc=%0d actual=%b expected=%b", i, err, mErr); end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_raw();
        test_intra_pair();
        test_reg0();
        test_waw_capacity();
        test_err_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
